// File: rtl/spi_tx_pkg.sv
// Shared types for the SPI transmit feeder: byte width and the frame sequencer states.
package spi_tx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/spi_tx_fifo.sv
// Byte FIFO with show-ahead read data, exact occupancy count and a sticky overflow flag.
// DEPTH must be a power of two so the pointers wrap naturally.
module spi_tx_fifo
    import spi_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [BYTE_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [BYTE_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Full is judged on the pre-edge count, so a write racing a pop while full is dropped.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full)
                overflow <= 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_tx_feeder.sv
// Feeds buffered host bytes to the SPI master one frame at a time: newd request, wait for
// completion, inter-frame gap. Define SPI_TX_TIMEOUT_EN to add the ISSUE+WAIT watchdog.
module spi_tx_feeder
    import spi_tx_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int NEWD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
`ifdef SPI_TX_TIMEOUT_EN
    , parameter int TIMEOUT   = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [BYTE_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   newd,
    output logic [BYTE_W-1:0]      din,
    input  logic                   done_sending,
    output logic                   busy
`ifdef SPI_TX_TIMEOUT_EN
    , output logic                 timeout_err
`endif
);

    localparam int PH_MAX = (NEWD_CYCLES > GAP_CYCLES) ? NEWD_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX) + 1;

    state_t            state, state_d;
    logic [PH_W-1:0]   ph_cnt, ph_cnt_d;
    logic              done_pend, done_pend_d;
    logic [1:0]        done_pipe;
    logic              done_rise;
    logic              pop;
    logic              to_hit;
    logic [BYTE_W-1:0] head;

    spi_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    // Registered completion, then rising-edge detect: a held level counts once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            done_pipe <= '0;
        else
            done_pipe <= {done_pipe[0], done_sending};
    end
    assign done_rise = done_pipe[0] && !done_pipe[1];

`ifdef SPI_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;

    logic [TO_W-1:0] to_cnt;
    logic            terr_q;

    // A completion seen in the same cycle as the limit wins over the timeout.
    assign to_hit = (state == ISSUE || state == WAIT) && (to_cnt == TO_W'(TIMEOUT - 1))
                    && !(done_rise || done_pend);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            terr_q <= 1'b0;
        end else begin
            if (pop)
                to_cnt <= '0;
            else if (state == ISSUE || state == WAIT)
                to_cnt <= to_cnt + 1'b1;
            if (to_hit)
                terr_q <= 1'b1;
        end
    end
    assign timeout_err = terr_q;
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ph_cnt    <= '0;
            done_pend <= 1'b0;
            din       <= '0;
        end else begin
            state     <= state_d;
            ph_cnt    <= ph_cnt_d;
            done_pend <= done_pend_d;
            if (pop)
                din <= head;
        end
    end

    always_comb begin
        state_d     = state;
        ph_cnt_d    = ph_cnt;
        done_pend_d = done_pend;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    state_d     = ISSUE;
                    ph_cnt_d    = '0;
                    done_pend_d = 1'b0;
                end
            end
            ISSUE: begin
                // An early completion is remembered and honoured on the first WAIT cycle.
                if (done_rise)
                    done_pend_d = 1'b1;
                if (to_hit) begin
                    state_d  = GAP;
                    ph_cnt_d = '0;
                end else if (ph_cnt == PH_W'(NEWD_CYCLES - 1)) begin
                    state_d  = WAIT;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt + 1'b1;
                end
            end
            WAIT: begin
                if (done_rise || done_pend) begin
                    state_d     = GAP;
                    ph_cnt_d    = '0;
                    done_pend_d = 1'b0;
                end else if (to_hit) begin
                    state_d  = GAP;
                    ph_cnt_d = '0;
                end
            end
            GAP: begin
                if (ph_cnt == PH_W'(GAP_CYCLES - 1))
                    state_d = IDLE;
                else
                    ph_cnt_d = ph_cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign newd = (state == ISSUE);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed bench for spi_tx_feeder: frame-interval model checked every cycle plus literal pins.
module tb_spi_tx_feeder;

    localparam int DEPTH = 8;
    localparam int NC    = 8;
    localparam int GC    = 4;
    localparam int TO    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          done_sending = 1'b0;
    logic          full, empty, overflow, newd, busy, timeout_err;
    logic [CW-1:0] count;
    logic [7:0]    din;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_tx_feeder #(
        .DEPTH       (DEPTH),
        .NEWD_CYCLES (NC),
        .GAP_CYCLES  (GC)
`ifdef SPI_TX_TIMEOUT_EN
        , .TIMEOUT   (TO)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .newd         (newd),
        .din          (din),
        .done_sending (done_sending),
        .busy         (busy)
`ifdef SPI_TX_TIMEOUT_EN
        , .timeout_err (timeout_err)
`endif
    );

`ifndef SPI_TX_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    // Model: a frame is a set of cycle intervals. ISSUE is [s, s+NC), the gap starts one cycle
    // after the later of the first completion rise and the end of ISSUE, and lasts GC cycles.
    logic [7:0] mq[$];
    int         k = 0;
    int         s = 0;
    int         gs = -1;
    bit         fr = 0;
    bit         m_ovf = 0;
    bit         m_terr = 0;
    bit         d_prev = 0;
    bit         idle_p, pop;
    int         pre;
    logic [7:0] m_din = 8'h00;
    logic       e_newd, e_busy;

    always @(posedge clk) begin
        k++;
        if (!rst) begin
            mq.delete();
            fr = 0; gs = -1; m_ovf = 0; m_terr = 0; d_prev = 0; m_din = 8'h00;
        end else begin
            idle_p = !fr || (gs >= 0 && k - 1 >= gs + GC);
            if (idle_p) fr = 0;
            pre = mq.size();
            pop = idle_p && pre > 0;
            if (wr_en) begin
                if (pre == DEPTH) m_ovf = 1;
                else mq.push_back(wr_data);
            end
            if (pop) begin
                m_din = mq.pop_front();
                fr = 1; s = k; gs = -1;
            end
`ifdef SPI_TX_TIMEOUT_EN
            if (fr && gs < 0 && k == s + TO) begin
                gs = k; m_terr = 1;
            end
`endif
            if (fr && gs < 0 && done_sending && !d_prev)
                gs = ((k > s + NC) ? k : s + NC) + 1;
            d_prev = done_sending;
        end
        e_newd = fr && k < s + NC;
        e_busy = fr && !(gs >= 0 && k >= gs + GC);
        #1;
        n_cmp++;
        if ({newd, busy, din, count, full, empty, overflow, timeout_err} !==
            {e_newd, e_busy, m_din, CW'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_ovf, m_terr}) begin
            n_bad++;
            $display("FAIL cycle%0d: got newd=%b busy=%b din=%h count=%0d full=%b empty=%b ovf=%b terr=%b, want newd=%b busy=%b din=%h count=%0d full=%b empty=%b ovf=%b terr=%b",
                     k, newd, busy, din, count, full, empty, overflow, timeout_err,
                     e_newd, e_busy, m_din, mq.size(), mq.size() == DEPTH, mq.size() == 0, m_ovf, m_terr);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    // sel: 0 newd high, 1 newd low, 2 busy low, 3 timeout_err high
    task automatic wait_sig(input int sel, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel == 0 && newd === 1'b1) || (sel == 1 && newd === 1'b0) ||
                (sel == 2 && busy === 1'b0) || (sel == 3 && timeout_err === 1'b1))
                return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_%s: not reached within %0d cycles", nm, budget);
    endtask

    task automatic wr(input logic [7:0] b);
        @(negedge clk); wr_en = 1'b1; wr_data = b;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); done_sending = 1'b1;
        @(negedge clk); done_sending = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_newd", newd, 0);  chk("rst_busy", busy, 0);  chk("rst_din", din, 8'h00);
        chk("rst_empty", empty, 1); chk("rst_count", count, 0); chk("rst_ovf", overflow, 0);
        rst = 1'b1;

        // Single byte: write edge N, newd visible after N+1 for NC cycles
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        chk("single_cnt_N", count, 1); chk("single_newd_N", newd, 0);
        @(negedge clk); wr_en = 1'b0;
        tick();
        chk("single_newd_N1", newd, 1); chk("single_din", din, 8'hA5); chk("single_cnt_N1", count, 0);
        repeat (7) tick();
        chk("single_newd_last", newd, 1);
        tick();
        chk("single_newd_drop", newd, 0); chk("single_busy_wait", busy, 1);

        // Burst while A5 waits for completion: fill, then one dropped write
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) begin
                chk("burst_full", full, 1); chk("burst_cnt8", count, 8); chk("burst_ovf0", overflow, 0);
            end
            wr_en = 1'b1; wr_data = (i < 8) ? 8'(i + 1) : 8'hFF;
        end
        @(negedge clk); wr_en = 1'b0;
        chk("burst_ovf1", overflow, 1); chk("burst_cnt_after", count, 8);

        @(negedge clk); done_sending = 1'b1;
        tick();
        @(negedge clk); done_sending = 1'b0;
        repeat (4) tick();
        chk("gap_busy_last", busy, 1);
        tick();
        chk("gap_idle", busy, 0);

        for (int j = 0; j < 4; j++) begin
            wait_sig(0, 20, "burst_newd");
            chk("burst_order", din, 8'(j + 1));
            wait_sig(1, 20, "burst_newd_lo");
            pulse_done();
        end

        // Completion level held for 50 clocks counts once: 05 completes, 06 stalls in WAIT
        wait_sig(0, 20, "held_newd");
        chk("held_din05", din, 8'h05); chk("held_cnt", count, 3);
        @(negedge clk); done_sending = 1'b1;
        repeat (50) @(negedge clk);
        done_sending = 1'b0;
        chk("held_din06", din, 8'h06); chk("held_newd", newd, 0); chk("held_busy", busy, 1);
        chk("held_cnt2", count, 2);

        // Simultaneous write and pop at count 3
        wr(8'h09);
        pulse_done();
        wait_sig(2, 20, "simul_idle");
        chk("simul_pre", count, 3);
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h0A;
        tick();
        chk("simul_cnt", count, 3); chk("simul_din", din, 8'h07); chk("simul_newd", newd, 1);
        @(negedge clk); wr_en = 1'b0;

        // Asynchronous reset mid-ISSUE
        @(negedge clk); rst = 1'b0;
        #1;
        chk("arst_newd", newd, 0); chk("arst_cnt", count, 0); chk("arst_busy", busy, 0);
        chk("arst_ovf", overflow, 0);
        @(negedge clk); rst = 1'b1;
        repeat (10) tick();
        chk("arst_quiet", {busy, newd}, 2'b00);

        // Write racing a pop while full is rejected
        wr(8'hA0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'hB1 + 8'(i);
        end
        @(negedge clk); wr_en = 1'b0;
        chk("full2_cnt", count, 8); chk("full2_ovf0", overflow, 0);
        wait_sig(1, 20, "full2_newd_lo");
        pulse_done();
        wait_sig(2, 20, "full2_idle");
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hCC;
        tick();
        chk("full2_drop_cnt", count, 7); chk("full2_ovf1", overflow, 1); chk("full2_din", din, 8'hB1);
        @(negedge clk); wr_en = 1'b0;

        // Drain the rest under the per-cycle model
        for (int j = 0; j < 8; j++) begin
            wait_sig(1, 20, "drain_newd_lo");
            pulse_done();
            wait_sig(2, 20, "drain_idle");
        end
        chk("drain_empty", empty, 1);

`ifdef SPI_TX_TIMEOUT_EN
        // No completion: watchdog fires, byte lost, next byte still issues
        wr(8'h55);
        wr(8'h66);
        wait_sig(3, 40, "timeout");
        chk("to_newd", newd, 0); chk("to_busy", busy, 1);
        wait_sig(0, 20, "to_next");
        chk("to_next_din", din, 8'h66);
        wait_sig(1, 20, "to_next_lo");
        pulse_done();
        wait_sig(2, 20, "to_idle");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
